siso_llr_combine: RTL and testbench
===================================

Name: siso_llr_combine

Overview:
- Downstream consumer of the alpha recursion and the beta/branch stream in the 8-state SISO max-log-MAP decoder.
- Buffers the forward metrics alpha_k for one block.
- Replays them in reverse order against the backward metrics beta_{k+1} and branch metrics gamma_k.
- Emits one saturated a-posteriori LLR per trellis step, in order k = N-1 down to 0.

Parameters:
- W, 16, metric/LLR width (signed).
- MAX_LEN, 516, maximum trellis steps per block (512 info + 4 tail).
- ADDR_W, $clog2(MAX_LEN), alpha buffer address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low; all state cleared while 0.
- blklen  in  16  trellis steps N for the next block.
- valid_blklen  in  1  blklen qualifier.
- alpha_0..alpha_7  in  W each  forward state metrics for step k.
- valid_alpha  in  1  alpha qualifier; one step per cycle, k ascending.
- beta_0..beta_7  in  W each  backward metrics beta_{k+1}.
- init_branch1, init_branch2  in  W each  gamma_k branch metrics.
- valid_beta  in  1  qualifier for beta and branch inputs; k descending.
- llr  out  W  a-posteriori LLR for step k.
- valid_llr  out  1  llr qualifier.
- llr_last  out  1  high with the k=0 output.
- busy  out  1  high outside IDLE.
- err_proto  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset values: llr=0, valid_llr=0, llr_last=0, busy=0, err_proto=0. FSM goes to IDLE and all counters and pipeline valids clear. Buffer contents are don't-care.
- Reset mid-block aborts the block; no partial output after release.
- FSM states:
  - IDLE: on valid_blklen with 1<=blklen<=MAX_LEN, latch N, set wr=0, go to FILL. Otherwise pulse err_proto and stay.
  - FILL: each valid_alpha writes all 8 alphas at address wr, then wr++. When wr reaches N-1 and is written, set rd=N-1 and go to DRAIN.
  - DRAIN: each valid_beta reads alpha[rd], then rd--. The beat with rd=0 moves to FLUSH.
  - FLUSH: wait until the pipeline is empty (the llr_last beat has been emitted), then go to IDLE. busy drops the cycle after llr_last.
- Protocol errors (each pulses err_proto and the sample is ignored, not written):
  - valid_beta in IDLE or FILL.
  - valid_alpha in IDLE, DRAIN or FLUSH.
  - valid_blklen outside IDLE.
- valid_alpha and valid_beta in the same cycle are legal only in FILL, where the beta is the error; the same rule applies in DRAIN with the roles swapped.
- Trellis rules:
  - Branch select: states {0,1,6,7} use init_branch1 (g1); states {2,3,4,5} use init_branch2 (g2).
  - T1[s] = alpha_s - g(s) + beta_{P1[s]}, with P1 = {4,0,1,5,6,2,3,7}.
  - T2[s] = alpha_s + g(s) + beta_{P2[s]}, with P2 = {0,4,5,1,2,6,7,3}.
  - llr = sat_W( max_s T1 - max_s T2 ).
- Width rules: sums are sign-extended to W+2 bits. Max is a signed compare; on ties the lower index wins. The difference is W+3 bits, saturated to [-2^(W-1), 2^(W-1)-1].
- Pipeline, fixed latency of 6 cycles from valid_beta to valid_llr:
  - 1: RAM read; beta and gamma registered alongside.
  - 2: 16 sums.
  - 3-5: 3-level max tree.
  - 6: subtract and saturate.
- The pipeline is never stalled. There is no ready signal, so upstream must honour the FSM phases.
- llr_last is aligned with the beat read from rd=0.

Decomposition:
- Package siso_pkg holds:
  - W and NUM_STATES=8.
  - Arrays P1 and P2 and the branch-select mask 8'b1100_0011.
  - FSM state enum {IDLE, FILL, DRAIN, FLUSH}.
  - Saturation function sat_w.
- Sub-module llr_alpha_ram: simple dual-port, 8*W wide, MAX_LEN deep, one write port, registered 1-cycle read, no reset on the array.

Test Plan:
1. Constant metrics, N=4: all alpha=0, all beta=0, g1=g2=10 -> four llr=-20 exactly 6 cycles after each valid_beta; llr_last on the 4th; busy falls next cycle.
2. Reverse addressing, N=4:
   - Stimulus: alpha_0[k]=10k, alpha_1[k]=0, other alphas -1000; beta_4=0, other betas -2000; g=0.
   - Response: llr sequence 30,20,10,0, with llr_last on 0.
3. Saturation: all alpha=30000, all beta=30000, g1=g2=-30000 -> llr=32767. Swap g signs to +30000 -> llr=-32768.
4. Max-length block: N=516, random metrics -> 516 outputs matching a bit-true model, in order k=515..0, with no gaps under back-to-back valid_beta.
5. Protocol errors -> err_proto pulses each time, state unchanged, outputs unaffected:
   - blklen=0 or 517.
   - valid_beta during FILL.
   - valid_alpha during DRAIN.
6. Mid-block reset: rst low for 1 cycle in DRAIN after 2 outputs -> all outputs 0 next edge, no further valid_llr. A new N=4 block then completes correctly.

Source files
------------

// File: rtl/siso_pkg.sv
// siso_pkg: shared constants, trellis tables and helpers
// for the SISO max-log-MAP LLR combine slice.
package siso_pkg;

  localparam int W          = 16;
  localparam int NUM_STATES = 8;

  localparam int P1 [NUM_STATES] = '{4, 0, 1, 5, 6, 2, 3, 7};
  localparam int P2 [NUM_STATES] = '{0, 4, 5, 1, 2, 6, 7, 3};

  // bit s set: state s uses init_branch1, else init_branch2
  localparam logic [NUM_STATES-1:0] G1_MASK = 8'b1100_0011;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    FLUSH
  } state_t;

  function automatic logic signed [W-1:0] sat_w(
    input logic signed [W+2:0] x
  );
    logic signed [W+2:0] hi;
    logic signed [W+2:0] lo;
    hi = {{4{1'b0}}, {(W-1){1'b1}}};
    lo = {{4{1'b1}}, {(W-1){1'b0}}};
    if (x > hi) return {1'b0, {(W-1){1'b1}}};
    if (x < lo) return {1'b1, {(W-1){1'b0}}};
    return x[W-1:0];
  endfunction

endpackage

// File: rtl/llr_alpha_ram.sv
// llr_alpha_ram: simple dual-port alpha buffer,
// one write port, registered one-cycle read.
module llr_alpha_ram #(
  parameter int DW    = 128,
  parameter int DEPTH = 516,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write all 8 alphas of one trellis step
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read for the reverse replay
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/siso_llr_combine.sv
// siso_llr_combine: buffers alpha per block, replays it in
// reverse against beta/gamma and emits saturated LLRs.
module siso_llr_combine
  import siso_pkg::*;
#(
  parameter int W       = siso_pkg::W,
  parameter int MAX_LEN = 516,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         blklen,
  input  logic                valid_blklen,
  input  logic signed [W-1:0] alpha_0,
  input  logic signed [W-1:0] alpha_1,
  input  logic signed [W-1:0] alpha_2,
  input  logic signed [W-1:0] alpha_3,
  input  logic signed [W-1:0] alpha_4,
  input  logic signed [W-1:0] alpha_5,
  input  logic signed [W-1:0] alpha_6,
  input  logic signed [W-1:0] alpha_7,
  input  logic                valid_alpha,
  input  logic signed [W-1:0] beta_0,
  input  logic signed [W-1:0] beta_1,
  input  logic signed [W-1:0] beta_2,
  input  logic signed [W-1:0] beta_3,
  input  logic signed [W-1:0] beta_4,
  input  logic signed [W-1:0] beta_5,
  input  logic signed [W-1:0] beta_6,
  input  logic signed [W-1:0] beta_7,
  input  logic signed [W-1:0] init_branch1,
  input  logic signed [W-1:0] init_branch2,
  input  logic                valid_beta,
  output logic signed [W-1:0] llr,
  output logic                valid_llr,
  output logic                llr_last,
  output logic                busy,
  output logic                err_proto
);

  localparam int SW = W + 2;
  typedef logic signed [SW-1:0] sum_t;

  function automatic sum_t smax(input sum_t a, input sum_t b);
    return (b > a) ? b : a;
  endfunction

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr, wr_n;
  logic [ADDR_W-1:0]   rd, rd_n;
  logic [ADDR_W-1:0]   nm1, nm1_n;
  logic                we, iss, iss_last, err_n;

  logic [8*W-1:0]      alpha_pack;
  logic [8*W-1:0]      ram_q;
  logic signed [W-1:0] beta_v  [NUM_STATES];
  logic signed [W-1:0] alpha_q [NUM_STATES];
  logic signed [W-1:0] g_sel   [NUM_STATES];

  logic signed [W-1:0] s1_beta [NUM_STATES];
  logic signed [W-1:0] s1_g1, s1_g2;
  sum_t                t1_c    [NUM_STATES];
  sum_t                t2_c    [NUM_STATES];
  sum_t                s2_t1   [NUM_STATES];
  sum_t                s2_t2   [NUM_STATES];
  sum_t                s3_m1   [4];
  sum_t                s3_m2   [4];
  sum_t                s4_m1   [2];
  sum_t                s4_m2   [2];
  sum_t                s5_m1, s5_m2;
  logic signed [SW:0]  diff_c;
  logic [5:1]          pv, pl;

  assign alpha_pack = {alpha_7, alpha_6, alpha_5, alpha_4,
                       alpha_3, alpha_2, alpha_1, alpha_0};

  assign beta_v[0] = beta_0;
  assign beta_v[1] = beta_1;
  assign beta_v[2] = beta_2;
  assign beta_v[3] = beta_3;
  assign beta_v[4] = beta_4;
  assign beta_v[5] = beta_5;
  assign beta_v[6] = beta_6;
  assign beta_v[7] = beta_7;

  assign busy = (state != IDLE);

  // FSM state, address counters and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr        <= '0;
      rd        <= '0;
      nm1       <= '0;
      err_proto <= 1'b0;
    end else begin
      state     <= state_n;
      wr        <= wr_n;
      rd        <= rd_n;
      nm1       <= nm1_n;
      err_proto <= err_n;
    end
  end

  // next-state, buffer write/read issue and protocol checks
  always_comb begin
    state_n  = state;
    wr_n     = wr;
    rd_n     = rd;
    nm1_n    = nm1;
    we       = 1'b0;
    iss      = 1'b0;
    iss_last = 1'b0;
    err_n    = 1'b0;
    if (valid_blklen && state != IDLE) err_n = 1'b1;
    if (valid_alpha && state != FILL)  err_n = 1'b1;
    if (valid_beta && state != DRAIN)  err_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (valid_blklen) begin
          if (blklen != '0 &&
              blklen <= 16'(MAX_LEN)) begin
            nm1_n   = ADDR_W'(blklen - 16'd1);
            wr_n    = '0;
            state_n = FILL;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      FILL: begin
        if (valid_alpha) begin
          we = 1'b1;
          if (wr == nm1) begin
            rd_n    = nm1;
            state_n = DRAIN;
          end else begin
            wr_n = wr + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (valid_beta) begin
          iss      = 1'b1;
          iss_last = (rd == '0);
          if (rd == '0) state_n = FLUSH;
          else          rd_n    = rd - ADDR_W'(1);
        end
      end
      FLUSH: begin
        if (llr_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  llr_alpha_ram #(
    .DW    (8 * W),
    .DEPTH (MAX_LEN),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr),
    .wdata (alpha_pack),
    .re    (iss),
    .raddr (rd),
    .rdata (ram_q)
  );

  // branch select and the 16 trellis sums
  always_comb begin
    for (int s = 0; s < NUM_STATES; s++) begin
      alpha_q[s] = ram_q[s*W +: W];
      g_sel[s]   = G1_MASK[s] ? s1_g1 : s1_g2;
      t1_c[s]    = sum_t'(alpha_q[s]) - sum_t'(g_sel[s])
                 + sum_t'(s1_beta[P1[s]]);
      t2_c[s]    = sum_t'(alpha_q[s]) + sum_t'(g_sel[s])
                 + sum_t'(s1_beta[P2[s]]);
    end
  end

  assign diff_c = {s5_m1[SW-1], s5_m1}
                - {s5_m2[SW-1], s5_m2};

  // six-stage datapath, never stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv        <= '0;
      pl        <= '0;
      s1_g1     <= '0;
      s1_g2     <= '0;
      s5_m1     <= '0;
      s5_m2     <= '0;
      llr       <= '0;
      valid_llr <= 1'b0;
      llr_last  <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        s1_beta[i] <= '0;
        s2_t1[i]   <= '0;
        s2_t2[i]   <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        s3_m1[i] <= '0;
        s3_m2[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        s4_m1[i] <= '0;
        s4_m2[i] <= '0;
      end
    end else begin
      pv    <= {pv[4:1], iss};
      pl    <= {pl[4:1], iss_last};
      s1_g1 <= init_branch1;
      s1_g2 <= init_branch2;
      for (int i = 0; i < NUM_STATES; i++) begin
        s1_beta[i] <= beta_v[i];
        s2_t1[i]   <= t1_c[i];
        s2_t2[i]   <= t2_c[i];
      end
      for (int i = 0; i < 4; i++) begin
        s3_m1[i] <= smax(s2_t1[2*i], s2_t1[2*i+1]);
        s3_m2[i] <= smax(s2_t2[2*i], s2_t2[2*i+1]);
      end
      for (int i = 0; i < 2; i++) begin
        s4_m1[i] <= smax(s3_m1[2*i], s3_m1[2*i+1]);
        s4_m2[i] <= smax(s3_m2[2*i], s3_m2[2*i+1]);
      end
      s5_m1     <= smax(s4_m1[0], s4_m1[1]);
      s5_m2     <= smax(s4_m2[0], s4_m2[1]);
      llr       <= sat_w(diff_c);
      valid_llr <= pv[5];
      llr_last  <= pl[5];
    end
  end

endmodule

// File: tb/tb_siso_llr_combine.sv
// tb_siso_llr_combine: scoreboard bench, random and directed
// blocks checked against a plain-arithmetic max-log model.
module tb_siso_llr_combine;

  localparam int W    = 16;
  localparam int MAXN = 516;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] blklen = '0;
  logic        valid_blklen = 1'b0;
  logic [W-1:0] alpha_0, alpha_1, alpha_2, alpha_3;
  logic [W-1:0] alpha_4, alpha_5, alpha_6, alpha_7;
  logic [W-1:0] beta_0, beta_1, beta_2, beta_3;
  logic [W-1:0] beta_4, beta_5, beta_6, beta_7;
  logic [W-1:0] init_branch1, init_branch2;
  logic        valid_alpha = 1'b0;
  logic        valid_beta = 1'b0;
  logic [W-1:0] llr;
  logic        valid_llr, llr_last, busy, err_proto;

  siso_llr_combine dut (
    .clk(clk), .rst(rst),
    .blklen(blklen), .valid_blklen(valid_blklen),
    .alpha_0(alpha_0), .alpha_1(alpha_1),
    .alpha_2(alpha_2), .alpha_3(alpha_3),
    .alpha_4(alpha_4), .alpha_5(alpha_5),
    .alpha_6(alpha_6), .alpha_7(alpha_7),
    .valid_alpha(valid_alpha),
    .beta_0(beta_0), .beta_1(beta_1),
    .beta_2(beta_2), .beta_3(beta_3),
    .beta_4(beta_4), .beta_5(beta_5),
    .beta_6(beta_6), .beta_7(beta_7),
    .init_branch1(init_branch1),
    .init_branch2(init_branch2),
    .valid_beta(valid_beta),
    .llr(llr), .valid_llr(valid_llr),
    .llr_last(llr_last), .busy(busy),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   errcnt = 0;
  int   outcnt = 0;

  int al [MAXN][8];
  int be [MAXN][8];
  int ga [MAXN];
  int gb [MAXN];
  int p1 [8] = '{4, 0, 1, 5, 6, 2, 3, 7};
  int p2 [8] = '{0, 4, 5, 1, 2, 6, 7, 3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // max-log reference: best path with bit 1 minus bit 0
  function automatic int ref_llr(input int k);
    int m1, m2, g, t1, t2, d;
    m1 = -(1 << 30);
    m2 = -(1 << 30);
    for (int s = 0; s < 8; s++) begin
      g  = (s < 2 || s > 5) ? ga[k] : gb[k];
      t1 = al[k][s] - g + be[k][p1[s]];
      t2 = al[k][s] + g + be[k][p2[s]];
      if (t1 > m1) m1 = t1;
      if (t2 > m2) m2 = t2;
    end
    d = m1 - m2;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  task automatic fill(input int mode, input int n);
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < 8; s++) begin
        unique case (mode)
          0: begin al[k][s] = 0; be[k][s] = 0; end
          1: begin
            al[k][s] = (s == 0) ? 10 * k :
                       (s == 1) ? 0 : -1000;
            be[k][s] = (s == 4) ? 0 : -2000;
          end
          2, 3: begin
            al[k][s] = 30000; be[k][s] = 30000;
          end
          default: begin
            al[k][s] = rnd16(); be[k][s] = rnd16();
          end
        endcase
      end
      unique case (mode)
        0: begin ga[k] = 10; gb[k] = 10; end
        1: begin ga[k] = 0; gb[k] = 0; end
        2: begin ga[k] = -30000; gb[k] = -30000; end
        3: begin ga[k] = 30000; gb[k] = 30000; end
        default: begin ga[k] = rnd16(); gb[k] = rnd16(); end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_blklen = 1'b0;
    valid_alpha  = 1'b0;
    valid_beta   = 1'b0;
  endtask

  task automatic set_alpha(input int k);
    alpha_0 = W'(al[k][0]); alpha_1 = W'(al[k][1]);
    alpha_2 = W'(al[k][2]); alpha_3 = W'(al[k][3]);
    alpha_4 = W'(al[k][4]); alpha_5 = W'(al[k][5]);
    alpha_6 = W'(al[k][6]); alpha_7 = W'(al[k][7]);
  endtask

  task automatic set_beta(input int k);
    beta_0 = W'(be[k][0]); beta_1 = W'(be[k][1]);
    beta_2 = W'(be[k][2]); beta_3 = W'(be[k][3]);
    beta_4 = W'(be[k][4]); beta_5 = W'(be[k][5]);
    beta_6 = W'(be[k][6]); beta_7 = W'(be[k][7]);
    init_branch1 = W'(ga[k]);
    init_branch2 = W'(gb[k]);
  endtask

  task automatic send_len(input int n);
    step();
    idle_in();
    blklen = 16'(n);
    valid_blklen = 1'b1;
  endtask

  task automatic send_alpha(input int k);
    step();
    idle_in();
    set_alpha(k);
    valid_alpha = 1'b1;
  endtask

  task automatic send_beta(input int k);
    exp_t e;
    step();
    idle_in();
    set_beta(k);
    valid_beta = 1'b1;
    e.v = ref_llr(k);
    e.last = (k == 0);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  // one full block; proto injects three illegal beats
  task automatic run_block(input string nm, input int n,
                           input bit proto);
    int e0;
    e0 = errcnt;
    send_len(n);
    for (int k = 0; k < n; k++) begin
      send_alpha(k);
      if (proto && k == 1) valid_beta = 1'b1;
      if (proto && k == 2) begin
        blklen = 16'd4;
        valid_blklen = 1'b1;
      end
    end
    for (int k = n - 1; k >= 0; k--) begin
      send_beta(k);
      if (proto && k == n - 2) valid_alpha = 1'b1;
    end
    step();
    idle_in();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk({nm, "_busy_at_last"}, int'(busy), 1);
    chk({nm, "_last_flag"}, int'(llr_last), 1);
    @(negedge clk);
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_err_count"}, errcnt - e0, proto ? 3 : 0);
  endtask

  // scoreboard monitor: pops one expectation per output
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
    end else begin
      if (err_proto) errcnt++;
      if (valid_llr) begin
        outcnt++;
        if (q.size() == 0) begin
          chk("unexpected_llr", int'($signed(llr)), 99999);
        end else begin
          e = q.pop_front();
          chk("llr_value", int'($signed(llr)), e.v);
          chk("llr_last", int'(llr_last), int'(e.last));
          chk("latency", cyc - e.cyc, 6);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e0, oc;
    alpha_0 = '0; alpha_1 = '0; alpha_2 = '0; alpha_3 = '0;
    alpha_4 = '0; alpha_5 = '0; alpha_6 = '0; alpha_7 = '0;
    beta_0 = '0; beta_1 = '0; beta_2 = '0; beta_3 = '0;
    beta_4 = '0; beta_5 = '0; beta_6 = '0; beta_7 = '0;
    init_branch1 = '0;
    init_branch2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_llr", int'(llr), 0);
    chk("rst_valid", int'(valid_llr), 0);
    chk("rst_last", int'(llr_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_proto), 0);
    step();
    rst = 1'b1;

    e0 = errcnt;
    send_len(0);
    send_len(517);
    step();
    idle_in();
    repeat (3) @(negedge clk);
    chk("bad_len_err", errcnt - e0, 2);
    chk("bad_len_busy", int'(busy), 0);

    fill(0, 4);
    run_block("const", 4, 1'b0);
    fill(1, 4);
    run_block("reverse", 4, 1'b0);
    fill(2, 2);
    run_block("sat_pos", 2, 1'b0);
    fill(3, 2);
    run_block("sat_neg", 2, 1'b0);
    fill(4, 1);
    run_block("len1", 1, 1'b0);
    fill(4, 6);
    run_block("proto", 6, 1'b1);
    fill(4, MAXN);
    run_block("maxlen", MAXN, 1'b0);

    fill(4, 8);
    send_len(8);
    for (int k = 0; k < 8; k++) send_alpha(k);
    send_beta(7);
    send_beta(6);
    send_beta(5);
    step();
    idle_in();
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_llr", int'(llr), 0);
    chk("mrst_valid", int'(valid_llr), 0);
    chk("mrst_last", int'(llr_last), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_err", int'(err_proto), 0);
    #1 rst = 1'b1;
    oc = outcnt;
    repeat (12) @(negedge clk);
    chk("mrst_no_output", outcnt - oc, 0);
    chk("mrst_idle", int'(busy), 0);
    fill(4, 4);
    run_block("after_rst", 4, 1'b0);

    for (int i = 0; i < 50 && q.size() != 0; i++)
      @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
